// File: rtl/rising_edge_detector_pkg.sv
// Shared constants and helpers for the rising-edge detector.
package rising_edge_detector_pkg;

    // Largest legal parameter values.
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_LEN_MAX  = 16;

    // Reset values for the synchronizer chain and for the filtered/previous level.
    // The level resets high so that an input already high at reset release
    // does not look like a fresh rising edge.
    localparam logic SYNC_RESET_VAL  = 1'b0;
    localparam logic LEVEL_RESET_VAL = 1'b1;

    // Width of the filter run-length counter.
    function automatic int filt_cnt_w(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/rising_edge_detector_if.sv
// Signal bundle between a requester and the rising-edge detector.
interface rising_edge_detector_if;

    logic Signal_In;
    logic EN;
    logic RiseEdge_Out;

    // Requester side: drives the level and the enable, watches the strobe.
    modport master (
        output Signal_In,
        output EN,
        input  RiseEdge_Out
    );

    // Detector side.
    modport slave (
        input  Signal_In,
        input  EN,
        output RiseEdge_Out
    );

endinterface

// File: rtl/rising_edge_detector_level_sync.sv
// N-stage flip-flop synchronizer with a configurable reset value.
module rising_edge_detector_level_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the input through the chain; reset clears every stage.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/rising_edge_detector.sv
// Rising-edge detector: optional synchronizer, run-length glitch filter,
// edge compare against the previous filtered level, registered pulse output.
module rising_edge_detector
    import rising_edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int FILTER_LEN  = 1
) (
    input  logic                 CLK_IN,
    input  logic                 RST_N,
    rising_edge_detector_if.slave bus
);

    localparam int               CNT_W    = filt_cnt_w(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             w_synced;
    logic             w_differs;
    logic             w_flip;
    logic             w_filtered;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("rising_edge_detector: SYNC_STAGES out of range 0..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filt
        $error("rising_edge_detector: FILTER_LEN out of range 1..16");
    end

    if (SYNC_STAGES > 0) begin : g_sync
        rising_edge_detector_level_sync #(
            .STAGES    (SYNC_STAGES),
            .RESET_VAL (SYNC_RESET_VAL)
        ) u_sync (
            .CLK_IN (CLK_IN),
            .RST_N  (RST_N),
            .i_d    (bus.Signal_In),
            .o_q    (w_synced)
        );
    end else begin : g_nosync
        assign w_synced = bus.Signal_In;
    end

    // Filtered level as seen this cycle: r_level holds the level settled at the
    // previous edge (and so doubles as the previous-level register); it flips
    // once the sample has differed for FILTER_LEN consecutive samples.
    // With FILTER_LEN=1 this collapses to the synced sample itself.
    always_comb begin
        w_differs  = (w_synced != r_level);
        w_flip     = w_differs && (r_cnt == CNT_LAST);
        w_filtered = w_flip ? w_synced : r_level;
    end

    // Count consecutive differing samples; cleared by a matching sample or a flip.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (w_differs && !w_flip) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Track the filtered level regardless of EN and register the gated edge pulse.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            r_level <= LEVEL_RESET_VAL;
            r_rise  <= 1'b0;
        end else begin
            r_level <= w_filtered;
            r_rise  <= bus.EN & w_filtered & ~r_level;
        end
    end

    assign bus.RiseEdge_Out = r_rise;

endmodule

// File: tb/tb_rising_edge_detector.sv
// Bench for rising_edge_detector: three configurations run side by side
// (default, 2-stage synchronizer, 4-sample filter) against a windowed model.
module tb_rising_edge_detector;

    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n;
    logic sin [3];
    logic en  [3];
    logic dout[3];

    always #5 clk = ~clk;

    rising_edge_detector_if if0();
    rising_edge_detector_if if1();
    rising_edge_detector_if if2();

    assign if0.Signal_In = sin[0];
    assign if1.Signal_In = sin[1];
    assign if2.Signal_In = sin[2];
    assign if0.EN = en[0];
    assign if1.EN = en[1];
    assign if2.EN = en[2];
    assign dout[0] = if0.RiseEdge_Out;
    assign dout[1] = if1.RiseEdge_Out;
    assign dout[2] = if2.RiseEdge_Out;

    rising_edge_detector #(.SYNC_STAGES(0), .FILTER_LEN(1)) u_dut0 (
        .CLK_IN(clk), .RST_N(rst_n), .bus(if0));
    rising_edge_detector #(.SYNC_STAGES(2), .FILTER_LEN(1)) u_dut1 (
        .CLK_IN(clk), .RST_N(rst_n), .bus(if1));
    rising_edge_detector #(.SYNC_STAGES(0), .FILTER_LEN(4)) u_dut2 (
        .CLK_IN(clk), .RST_N(rst_n), .bus(if2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit h_rst [MAXC];
    bit h_in  [3][MAXC];
    bit h_en  [3][MAXC];
    bit m_level[3];
    bit exp_o [3];
    int dcount[3];
    int dlast [3];
    int mcount[3];
    int mlast [3];

    function automatic int sst(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic int flen(input int d);
        return (d == 2) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clr();
        for (int d = 0; d < 3; d++) begin
            dcount[d] = 0; dlast[d] = -1; mcount[d] = 0; mlast[d] = -1;
        end
    endtask

    task automatic ncyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Sample the filter sees at edge n: the input S edges earlier, or 0 if a
    // reset edge fell inside the synchronizer's travel time.
    function automatic bit synced(input int d, input int n);
        int s;
        s = sst(d);
        if (s == 0) return h_in[d][n];
        if (n - s < 1) return 1'b0;
        for (int m = n - s; m < n; m++) begin
            if (h_rst[m]) return 1'b0;
        end
        return h_in[d][n-s];
    endfunction

    // Level flips at edge n when the last FILTER_LEN samples, all taken since
    // reset, differ from the current level; pulse on a 0->1 flip with EN high.
    function automatic bit model_step(input int d, input int n);
        bit flip;
        bit nl;
        bit o;
        if (h_rst[n]) begin
            m_level[d] = 1'b1;
            return 1'b0;
        end
        flip = 1'b1;
        for (int j = 0; j < flen(d); j++) begin
            if (n - j < 1) flip = 1'b0;
            else if (h_rst[n-j]) flip = 1'b0;
            else if (synced(d, n - j) == m_level[d]) flip = 1'b0;
        end
        nl = flip ? ~m_level[d] : m_level[d];
        o  = h_en[d][n] & nl & ~m_level[d];
        m_level[d] = nl;
        return o;
    endfunction

    // Record each edge's inputs, advance the model, compare just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (cyc < MAXC - 1) cyc++;
            h_rst[cyc] = !rst_n;
            for (int d = 0; d < 3; d++) begin
                h_in[d][cyc] = sin[d];
                h_en[d][cyc] = en[d];
            end
            for (int d = 0; d < 3; d++) exp_o[d] = model_step(d, cyc);
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d_out_edge%0d", d, cyc), int'(dout[d]), int'(exp_o[d]));
                if (dout[d]) begin dcount[d]++; dlast[d] = cyc; end
                if (exp_o[d]) begin mcount[d]++; mlast[d] = cyc; end
            end
        end
    end

    initial begin
        int r;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin sin[d] = 1'b0; en[d] = 1'b1; end
        clr();

        // Reset with inputs low.
        ncyc(3);
        chk("reset_out0", int'(dout[0]), 0);
        chk("reset_out1", int'(dout[1]), 0);
        chk("reset_out2", int'(dout[2]), 0);
        rst_n = 1'b1;
        ncyc(1);

        // Single rise on all; dut2 only sees a 3-sample glitch.
        clr();
        r = cyc + 1;
        sin[0] = 1'b1; sin[1] = 1'b1; sin[2] = 1'b1;
        ncyc(3);
        sin[2] = 1'b0;
        ncyc(7);
        chk("default_pulse_count", dcount[0], 1);
        chk("default_pulse_edge", dlast[0], r);
        chk("model_default_edge", mlast[0], r);
        chk("sync2_pulse_count", dcount[1], 1);
        chk("sync2_pulse_edge", dlast[1], r + 2);
        chk("model_sync2_edge", mlast[1], r + 2);
        chk("glitch3_no_pulse", dcount[2], 0);

        // Four-sample high passes the filter.
        clr();
        r = cyc + 1;
        sin[2] = 1'b1;
        ncyc(4);
        sin[2] = 1'b0;
        ncyc(4);
        chk("filter4_pulse_count", dcount[2], 1);
        chk("filter4_pulse_edge", dlast[2], r + 3);
        chk("model_filter4_edge", mlast[2], r + 3);

        // Toggle 0,1,0,1 on the default configuration.
        sin[0] = 1'b0;
        ncyc(1);
        clr();
        r = cyc + 1;
        sin[0] = 1'b1; ncyc(1);
        sin[0] = 1'b0; ncyc(1);
        sin[0] = 1'b1; ncyc(1);
        sin[0] = 1'b0; ncyc(2);
        chk("toggle_pulse_count", dcount[0], 2);
        chk("toggle_last_edge", dlast[0], r + 2);

        // Input held high through reset and after release.
        for (int d = 0; d < 3; d++) sin[d] = 1'b1;
        ncyc(2);
        rst_n = 1'b0;
        ncyc(3);
        rst_n = 1'b1;
        clr();
        ncyc(8);
        chk("high_at_reset_no_pulse0", dcount[0], 0);
        chk("high_at_reset_no_pulse2", dcount[2], 0);
        sin[0] = 1'b0; ncyc(1);
        clr();
        r = cyc + 1;
        sin[0] = 1'b1; ncyc(3);
        chk("after_reset_rise_count", dcount[0], 1);
        chk("after_reset_rise_edge", dlast[0], r);

        // Rise while EN is low, then EN raised with the signal still high.
        sin[0] = 1'b0; ncyc(3);
        en[0] = 1'b0;
        clr();
        sin[0] = 1'b1; ncyc(4);
        en[0] = 1'b1; ncyc(6);
        chk("en_low_edge_lost", dcount[0], 0);
        sin[0] = 1'b0; ncyc(2);
        clr();
        r = cyc + 1;
        sin[0] = 1'b1; ncyc(3);
        chk("en_high_rise_count", dcount[0], 1);
        chk("en_high_rise_edge", dlast[0], r);

        // Reset asserted in the cycle the pulse is high.
        sin[0] = 1'b0; ncyc(3);
        clr();
        r = cyc + 1;
        sin[0] = 1'b1; ncyc(1);
        chk("mid_pulse_high", int'(dout[0]), 1);
        rst_n = 1'b0; ncyc(1);
        chk("reset_clears_pulse", int'(dout[0]), 0);
        rst_n = 1'b1; ncyc(6);
        chk("no_pulse_after_reset_count", dcount[0], 1);
        chk("no_pulse_after_reset_edge", dlast[0], r);

        // Random run-length stimulus with occasional resets and EN drops.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(3) == 0) sin[d] = ~sin[d];
                en[d] = ($urandom_range(7) != 0);
            end
            rst_n = ($urandom_range(199) != 0);
        end
        rst_n = 1'b1;
        ncyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
